// File: rtl/timer_pkg.sv
// Shared definitions for the programmable timer: MODE field layout, named
// mode encodings and the run-state encoding.
package timer_pkg;

  // MODE bit positions
  localparam int MODE_DIR_BIT    = 1;  // 0 = count down, 1 = count up
  localparam int MODE_RELOAD_BIT = 0;  // 0 = one-shot,    1 = auto-reload

  // Named MODE encodings
  localparam logic [1:0] ONE_DOWN  = 2'b00;
  localparam logic [1:0] AUTO_DOWN = 2'b01;
  localparam logic [1:0] ONE_UP    = 2'b10;
  localparam logic [1:0] AUTO_UP   = 2'b11;

  // Timer run state
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable prescaler: emits a one-cycle tick every PRE+1 enabled cycles.
// The count holds while en is low and restarts from 0 on clr.
module tick_prescaler #(
  parameter int PRE_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] PRE,
  output logic                 tick
);

  logic [PRE_WIDTH-1:0] r_cnt;

  // >= rather than == so a PRE lowered below the current count still ticks
  // on the next enabled cycle instead of running all the way round.
  assign tick = en & (r_cnt >= PRE);

  // Phase counter: cleared by load, advances only on enabled cycles.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)    r_cnt <= '0;
    else if (clr) r_cnt <= '0;
    else if (en)  r_cnt <= tick ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/prog_timer.sv
// Programmable up/down timer with one-shot or auto-reload operation,
// prescaled count enable, registered terminal-count pulse and sticky DONE.
module prog_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int PRE_WIDTH = 4
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 LDn,
  input  logic                 E,
  input  logic [1:0]           MODE,
  input  logic [WIDTH-1:0]     PD,
  input  logic [PRE_WIDTH-1:0] PRE,
  input  logic                 CLR_DONE,
  output logic [WIDTH-1:0]     QT,
  output logic                 RCO,
  output logic                 TC,
  output logic                 DONE,
  output logic                 RUN
);

  state_t           r_state;
  logic [WIDTH-1:0] r_qt;
  logic             r_tc;
  logic             r_done;
  logic             r_run;

  logic w_up;
  logic w_auto;
  logic w_term;
  logic w_en;
  logic w_tick;

  assign w_up   = MODE[MODE_DIR_BIT];
  assign w_auto = MODE[MODE_RELOAD_BIT];
  // Up-mode uses >= so lowering PD below QT mid-run still terminates.
  assign w_term = w_up ? (r_qt >= PD) : (r_qt == '0);
  // Prescaler only runs while counting; IDLE and HALT ignore E.
  assign w_en   = E & (r_state == ST_RUN);

  tick_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_pre (
    .CLK  (CLK),
    .RSTn (RSTn),
    .clr  (~LDn),
    .en   (w_en),
    .PRE  (PRE),
    .tick (w_tick)
  );

  // Counter, run state and flags: load beats tick beats hold.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= ST_IDLE;
      r_qt    <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_run   <= 1'b0;
    end else if (!LDn) begin
      r_state <= ST_RUN;
      r_qt    <= w_up ? '0 : PD;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
      r_run   <= 1'b1;
    end else begin
      r_tc <= 1'b0;
      if (CLR_DONE) r_done <= 1'b0;
      if (w_tick) begin
        if (!w_term) begin
          r_qt <= w_up ? r_qt + 1'b1 : r_qt - 1'b1;
        end else begin
          r_tc <= 1'b1;
          if (w_auto) begin
            r_qt <= w_up ? '0 : PD;
          end else begin
            // One-shot completion; set overrides a coincident CLR_DONE.
            r_state <= ST_HALT;
            r_run   <= 1'b0;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  assign QT   = r_qt;
  assign RCO  = w_term;
  assign TC   = r_tc;
  assign DONE = r_done;
  assign RUN  = r_run;

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised programmable timer/counter; successor to the fixed 6-bit reload down-counter.
- Adds up or down direction, one-shot or auto-reload mode, a clock-enable prescaler, a registered terminal-count pulse and a sticky done flag.
- Sits under the clock/timer top level; drives display digits and cascades through TC into the next stage's E.

Parameters:
- WIDTH, 6, counter width in bits.
- PRE_WIDTH, 4, prescaler width in bits; divisor is PRE+1.

Ports:
- CLK  in  1  clock.
- RSTn  in  1  reset, asynchronous, active-low.
- LDn  in  1  synchronous load/start, active-low.
- E  in  1  count enable; gates prescaler and counter.
- MODE  in  2  bit1: 0=down, 1=up; bit0: 0=one-shot, 1=auto-reload.
- PD  in  WIDTH  preset/limit value.
- PRE  in  PRE_WIDTH  prescale value; a tick occurs every PRE+1 enabled cycles.
- CLR_DONE  in  1  synchronous clear of DONE.
- QT  out  WIDTH  current count.
- RCO  out  1  combinational; 1 while QT is at the terminal value for the current MODE.
- TC  out  1  registered one-cycle terminal-count pulse.
- DONE  out  1  sticky; set when a one-shot run completes.
- RUN  out  1  1 while in state RUN.

Behaviour:
- Reset (RSTn=0, immediate): QT=0, prescaler=0, state=IDLE, TC=0, DONE=0, RUN=0.
- States:
  - IDLE: waits for a load; E ignored.
  - RUN: counting.
  - HALT: one-shot finished; E ignored; only a load exits.
- Priority each edge: reset > load > tick > hold.
- Load (LDn=0, any state):
  - QT <= PD if MODE[1]=0, else 0.
  - Prescaler <= 0, state <= RUN, TC <= 0, DONE <= 0.
- Prescaler:
  - In RUN with E=1, it counts 0..PRE. A tick occurs on the cycle the prescaler equals PRE; the prescaler then returns to 0.
  - PRE=0 gives a tick every enabled cycle.
  - With E=0, the prescaler and QT both hold.
- Terminal value: down mode QT==0; up mode QT>=PD. Using >= covers PD lowered mid-run.
- RCO = terminal condition. It is not gated by E or state.
- On a tick in RUN:
  - Not at terminal: QT-1 (down) or QT+1 (up).
  - At terminal, auto-reload: QT <= PD (down) or 0 (up); TC=1 next cycle.
  - At terminal, one-shot: QT holds; state <= HALT; TC=1 next cycle; DONE <= 1.
- Auto-reload period = (PD+1)*(PRE+1) cycles.
- PD=0: down auto-reload produces TC on every tick.
- TC is 0 in every cycle not immediately following a terminal tick.
- MODE and PD are sampled at each tick. A MODE change mid-run continues from the current QT with no reload.
- DONE: CLR_DONE=1 clears it. If CLR_DONE coincides with the set event, set wins.
- RUN = (state==RUN).
- All arithmetic is WIDTH bits unsigned. No wrap occurs past 0 or 2^WIDTH-1, because the terminal check precedes the increment/decrement.

Decomposition:
- timer_pkg: MODE bit positions and named encodings (ONE_DOWN=2'b00, AUTO_DOWN=2'b01, ONE_UP=2'b10, AUTO_UP=2'b11), 2-bit state encoding (IDLE, RUN, HALT).
- Sub-module tick_prescaler:
  - Inputs: CLK, RSTn, clr, en, PRE.
  - Output: tick.
  - Instantiated once.
- Counter, FSM and flags live in prog_timer.

Test Plan:
- MODE=01, PD=5, PRE=0, E=1, LDn pulse -> QT 5,4,3,2,1,0,5,4…; TC high 1 cycle after each QT=0 tick (every 6 cycles); RCO=1 exactly while QT=0.
- MODE=00, PD=3, PRE=2 -> QT steps every 3 cycles 3,2,1,0 -> TC once, DONE=1, RUN=0, QT stays 0 through 20 more cycles with E=1; then CLR_DONE=1 -> DONE=0.
- MODE=11, PD=4, PRE=1 -> QT 0..4 every 2 cycles, then wraps to 0 with TC; lower PD to 2 while QT=3 -> next tick wraps to 0.
- E=0 for 5 cycles mid-run at QT=7 (WIDTH=6, PD=9) -> QT and prescaler frozen; E=1 -> resumes at identical phase.
- Assert RSTn=0 mid-cycle while QT=4 -> QT=0, RUN=0, DONE=0 immediately without a clock edge; after release with E=1 and no load, QT stays 0 (IDLE).
- LDn=0 on the same edge as a terminal tick (MODE=00) -> QT=PD, state RUN, TC=0, DONE=0.
